// File: rtl/tt_ctrl_sel_decoder.sv
// Rebuilds the selected design address from the autoselect mux-control pins and presents it to the mux decode.
// Latency: count and sel_valid/ena_o update SYNC_STAGES+1 clk edges after the first edge that samples a raw pin change.
// Backpressure: none; the pins are free-running level/edge signals, and a pulse shorter than one clk period may be lost.
module tt_ctrl_sel_decoder #(
    parameter int ADDR_W      = 10,
    parameter int MAX_ADDR    = 1023,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_sel_rst_n,
    input  logic              ctrl_sel_inc,
    input  logic              ctrl_ena,
    output logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] sel_addr,
    output logic              sel_valid,
    output logic              ena_o,
    output logic              overflow,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_COUNT  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);

    logic [SYNC_STAGES-1:0] srst_sync_q;
    logic [SYNC_STAGES-1:0] inc_sync_q;
    logic [SYNC_STAGES-1:0] ena_sync_q;
    logic                   inc_prev_q;
    logic                   ena_prev_q;

    logic                   srst_s;
    logic                   inc_s;
    logic                   ena_s;
    logic                   inc_edge;
    logic                   ena_edge;

    state_e                 state_q,    state_d;
    logic [ADDR_W-1:0]      count_q,    count_d;
    logic [ADDR_W-1:0]      sel_addr_q, sel_addr_d;
    logic                   valid_q,    valid_d;
    logic                   ovf_q,      ovf_d;
    logic                   perr_q,     perr_d;
    logic [ADDR_W-1:0]      count_inc;
    logic                   at_max;

    // Bring the three raw pins into the clk domain and keep one previous-value flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srst_sync_q <= '0;
            inc_sync_q  <= '0;
            ena_sync_q  <= '0;
            inc_prev_q  <= 1'b0;
            ena_prev_q  <= 1'b0;
        end else begin
            srst_sync_q <= {srst_sync_q[SYNC_STAGES-2:0], ctrl_sel_rst_n};
            inc_sync_q  <= {inc_sync_q[SYNC_STAGES-2:0], ctrl_sel_inc};
            ena_sync_q  <= {ena_sync_q[SYNC_STAGES-2:0], ctrl_ena};
            inc_prev_q  <= inc_sync_q[SYNC_STAGES-1];
            ena_prev_q  <= ena_sync_q[SYNC_STAGES-1];
        end
    end

    assign srst_s   = srst_sync_q[SYNC_STAGES-1];
    assign inc_s    = inc_sync_q[SYNC_STAGES-1];
    assign ena_s    = ena_sync_q[SYNC_STAGES-1];
    assign inc_edge = inc_s & ~inc_prev_q;
    assign ena_edge = ena_s & ~ena_prev_q;

    assign at_max    = (count_q == MAX_A);
    assign count_inc = at_max ? '0 : count_q + 1'b1;

    // Selection FSM; sel_rst_n low overrides everything and drops any edges seen in the same cycle.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        sel_addr_d = sel_addr_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        perr_d     = perr_q;
        if (!srst_s) begin
            state_d = ST_RESET;
            count_d = '0;
            ovf_d   = 1'b0;
            perr_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    state_d = ST_COUNT;
                end
                ST_COUNT: begin
                    if (inc_edge) begin
                        count_d = count_inc;
                        if (at_max) begin
                            ovf_d = 1'b1;
                        end
                    end
                    // A coincident increment lands first, so the latched address includes it.
                    if (ena_edge) begin
                        state_d    = ST_ACTIVE;
                        sel_addr_d = inc_edge ? count_inc : count_q;
                        valid_d    = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (inc_edge) begin
                        perr_d = 1'b1;
                    end
                    // Count is kept so a later reselection continues from the current address.
                    if (!ena_s) begin
                        state_d = ST_COUNT;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            count_q    <= '0;
            sel_addr_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sel_addr_q <= sel_addr_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
        end
    end

    assign count     = count_q;
    assign sel_addr  = sel_addr_q;
    assign sel_valid = valid_q;
    assign ena_o     = valid_q;
    assign overflow  = ovf_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_tt_ctrl_sel_decoder.sv
// Self-checking bench for tt_ctrl_sel_decoder: a default instance plus a MAX_ADDR=3 instance sharing the pins.
// Latency: inputs driven and outputs sampled on the falling clk edge, each vector held for a fixed cycle count.
// Backpressure: none; expected records go through a scoreboard queue between drive and check.
module tb_tt_ctrl_sel_decoder;

    logic       clk;
    logic       rst_n;
    logic       sel_rst_n;
    logic       inc;
    logic       ena;

    logic [9:0] d_count, d_addr;
    logic       d_valid, d_ena, d_ovf, d_perr;
    logic [9:0] w_count, w_addr;
    logic       w_valid, w_ena, w_ovf, w_perr;

    int n_cmp;
    int n_err;

    typedef struct {
        logic srst;
        logic inc;
        logic ena;
        int   cyc;
        int   c;
        int   a;
        int   v;
        int   o;
        int   p;
        int   wc;
        int   wo;
    } vec_t;

    vec_t vec_q[$];
    vec_t sb_q[$];
    vec_t cur;
    vec_t exp_r;

    tt_ctrl_sel_decoder u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctrl_sel_rst_n (sel_rst_n),
        .ctrl_sel_inc   (inc),
        .ctrl_ena       (ena),
        .count          (d_count),
        .sel_addr       (d_addr),
        .sel_valid      (d_valid),
        .ena_o          (d_ena),
        .overflow       (d_ovf),
        .proto_err      (d_perr)
    );

    tt_ctrl_sel_decoder #(.ADDR_W(10), .MAX_ADDR(3), .SYNC_STAGES(2)) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctrl_sel_rst_n (sel_rst_n),
        .ctrl_sel_inc   (inc),
        .ctrl_ena       (ena),
        .count          (w_count),
        .sel_addr       (w_addr),
        .sel_valid      (w_valid),
        .ena_o          (w_ena),
        .overflow       (w_ovf),
        .proto_err      (w_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic s, input logic i, input logic e, input int cyc,
                           input int c, input int a, input int v, input int o, input int p,
                           input int wc, input int wo);
        vec_t r;
        r.srst = s; r.inc = i; r.ena = e; r.cyc = cyc;
        r.c = c; r.a = a; r.v = v; r.o = o; r.p = p; r.wc = wc; r.wo = wo;
        vec_q.push_back(r);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".count"}, d_count, 0);
        chk({tag, ".sel_addr"}, d_addr, 0);
        chk({tag, ".sel_valid"}, d_valid, 0);
        chk({tag, ".ena_o"}, d_ena, 0);
        chk({tag, ".overflow"}, d_ovf, 0);
        chk({tag, ".proto_err"}, d_perr, 0);
        chk({tag, ".w_count"}, w_count, 0);
        chk({tag, ".w_valid"}, w_valid, 0);
        chk({tag, ".w_overflow"}, w_ovf, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        sel_rst_n = 1'b1;
        inc = 1'b0;
        ena = 1'b0;

        // Vector table: pins, hold cycles, expected main outputs, expected wrap-instance count/overflow.
        add_vec(1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            add_vec(1, 1, 0, 4, k, 0, 0, 0, 0, k % 4, (k >= 4) ? 1 : 0);
            add_vec(1, 0, 0, 4, k, 0, 0, 0, 0, k % 4, (k >= 4) ? 1 : 0);
        end
        // Enable: not yet visible two cycles after the rise, visible on the third.
        add_vec(1, 0, 1, 2, 5, 0, 0, 0, 0, 1, 1);
        add_vec(1, 0, 1, 1, 5, 5, 1, 0, 0, 1, 1);
        // Increments while active flag an error and leave count/sel_addr alone.
        for (int k = 0; k < 2; k++) begin
            add_vec(1, 1, 1, 4, 5, 5, 1, 0, 1, 1, 1);
            add_vec(1, 0, 1, 4, 5, 5, 1, 0, 1, 1, 1);
        end
        add_vec(1, 0, 0, 4, 5, 5, 0, 0, 1, 1, 1);
        add_vec(1, 1, 0, 4, 6, 5, 0, 0, 1, 2, 1);
        add_vec(1, 0, 0, 4, 6, 5, 0, 0, 1, 2, 1);
        add_vec(1, 0, 1, 4, 6, 6, 1, 0, 1, 2, 1);
        // Selection reset while active; an ena rise during the low period must not enable.
        add_vec(0, 0, 1, 4, 0, 6, 0, 0, 0, 0, 0);
        add_vec(0, 0, 0, 4, 0, 6, 0, 0, 0, 0, 0);
        add_vec(0, 0, 1, 4, 0, 6, 0, 0, 0, 0, 0);
        add_vec(1, 0, 1, 4, 0, 6, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 4, 0, 6, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            add_vec(1, 1, 0, 4, k, 6, 0, 0, 0, k % 4, (k >= 4) ? 1 : 0);
            add_vec(1, 0, 0, 4, k, 6, 0, 0, 0, k % 4, (k >= 4) ? 1 : 0);
        end

        // Reset state while rst_n is held low.
        @(negedge clk);
        chk_all_zero("in_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("post_release");
        @(negedge clk);

        for (int i = 0; i < vec_q.size(); i++) begin
            cur = vec_q[i];
            sb_q.push_back(cur);
            sel_rst_n = cur.srst;
            inc = cur.inc;
            ena = cur.ena;
            repeat (cur.cyc) @(negedge clk);
            exp_r = sb_q.pop_front();
            chk($sformatf("v%0d.count", i), d_count, exp_r.c);
            chk($sformatf("v%0d.sel_addr", i), d_addr, exp_r.a);
            chk($sformatf("v%0d.sel_valid", i), d_valid, exp_r.v);
            chk($sformatf("v%0d.ena_o", i), d_ena, exp_r.v);
            chk($sformatf("v%0d.overflow", i), d_ovf, exp_r.o);
            chk($sformatf("v%0d.proto_err", i), d_perr, exp_r.p);
            chk($sformatf("v%0d.w_count", i), w_count, exp_r.wc);
            chk($sformatf("v%0d.w_overflow", i), w_ovf, exp_r.wo);
        end

        // Simultaneous inc and ena rise: main goes 7->8 and latches 8; wrap instance wraps 3->0 and latches 0.
        inc = 1'b1;
        ena = 1'b1;
        repeat (2) @(negedge clk);
        chk("simul.pre_count", d_count, 7);
        chk("simul.pre_valid", d_valid, 0);
        chk("simul.pre_w_count", w_count, 3);
        @(negedge clk);
        chk("simul.count", d_count, 8);
        chk("simul.sel_addr", d_addr, 8);
        chk("simul.sel_valid", d_valid, 1);
        chk("simul.ena_o", d_ena, 1);
        chk("simul.overflow", d_ovf, 0);
        chk("simul.w_count", w_count, 0);
        chk("simul.w_sel_addr", w_addr, 0);
        chk("simul.w_sel_valid", w_valid, 1);
        chk("simul.w_ena_o", w_ena, 1);
        chk("simul.w_overflow", w_ovf, 1);
        chk("simul.w_proto_err", w_perr, 0);

        // rst_n asserted mid-activity clears all outputs without waiting for a clock edge.
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        chk("async_reset.w_sel_addr", w_addr, 0);
        chk("async_reset.w_proto_err", w_perr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
